// File: rtl/tlb_ctl.sv
// Sequencer for the two-group translation buffer: lookup, fill, invalidate-one, invalidate-all.
// Latency: lookup/fill/inv-one 2 cycles to done_h, inv-all 2**IDX_W+1 cycles. Requests are held levels, no stall.
// Optional TLB_PERR_RETRY_EN: parity faults invalidate the entry and report a miss instead of a machine check.
module tlb_ctl #(
    parameter int IDX_W      = 8,
    parameter int PERR_CNT_W = 4
) (
    input  logic                  b_clk_l,
    input  logic                  init_l,
    input  logic                  lookup_req_h,
    input  logic                  fill_req_h,
    input  logic                  inv_one_req_h,
    input  logic                  inv_all_req_h,
    input  logic [IDX_W-1:0]      index_h,
    input  logic                  diag_force_pe_h,
    input  logic [1:0]            tb_hit_out_h,
    input  logic [1:0]            tb_tag_perr_h,
    input  logic                  tb_data_perr_h,
    output logic [1:0]            tb_grp_wr_h,
    output logic [1:0]            tb_hit_h,
    output logic                  tb_output_ena_l,
    output logic                  pte_check_l,
    output logic                  force_tb_pe_l,
    output logic                  inv_active_h,
    output logic [IDX_W-1:0]      inv_index_h,
    output logic                  clear_valid_h,
    output logic                  busy_h,
    output logic                  done_h,
    output logic                  miss_h,
    output logic                  mchk_h,
    output logic [PERR_CNT_W-1:0] perr_cnt_h
);
    localparam int N_ENT = 2**IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, INV_ONE, INV_ALL} state_t;

    state_t           state;
    logic [N_ENT-1:0] lru;
    logic [IDX_W-1:0] idx_q;
`ifdef TLB_PERR_RETRY_EN
    logic             retry_q;
`endif

    logic hit_one, hit_grp, fault, victim;

    // Tag parity only matters on a group that actually hit.
    assign hit_one = tb_hit_out_h[0] ^ tb_hit_out_h[1];
    assign hit_grp = tb_hit_out_h[1];
    assign fault   = (&tb_hit_out_h) | (|(tb_tag_perr_h & tb_hit_out_h)) | tb_data_perr_h;
    assign victim  = ~lru[index_h];

    always_ff @(posedge b_clk_l) begin
        if (!init_l) begin
            state           <= IDLE;
            lru             <= '0;
            idx_q           <= '0;
`ifdef TLB_PERR_RETRY_EN
            retry_q         <= 1'b0;
`endif
            tb_grp_wr_h     <= 2'b00;
            tb_hit_h        <= 2'b00;
            tb_output_ena_l <= 1'b1;
            pte_check_l     <= 1'b1;
            force_tb_pe_l   <= 1'b1;
            inv_active_h    <= 1'b0;
            inv_index_h     <= '0;
            clear_valid_h   <= 1'b0;
            busy_h          <= 1'b0;
            done_h          <= 1'b0;
            miss_h          <= 1'b0;
            mchk_h          <= 1'b0;
            perr_cnt_h      <= '0;
        end else begin
            force_tb_pe_l <= ~diag_force_pe_h;
            done_h        <= 1'b0;
            mchk_h        <= 1'b0;
            case (state)
                IDLE: begin
                    // Skip the done cycle so a still-held request is not taken twice.
                    if (!done_h) begin
                        if (inv_all_req_h) begin
                            state         <= INV_ALL;
                            busy_h        <= 1'b1;
                            inv_active_h  <= 1'b1;
                            clear_valid_h <= 1'b1;
                            tb_grp_wr_h   <= 2'b11;
                            inv_index_h   <= '0;
                        end else if (inv_one_req_h) begin
                            state         <= INV_ONE;
                            busy_h        <= 1'b1;
                            clear_valid_h <= 1'b1;
                            tb_grp_wr_h   <= 2'b11;
                            lru[index_h]  <= 1'b0;
                            idx_q         <= index_h;
                        end else if (fill_req_h) begin
                            state         <= FILL;
                            busy_h        <= 1'b1;
                            pte_check_l   <= 1'b0;
                            tb_grp_wr_h   <= {victim, ~victim};
                            lru[index_h]  <= victim;
                            idx_q         <= index_h;
                        end else if (lookup_req_h) begin
                            state           <= LOOKUP;
                            busy_h          <= 1'b1;
                            tb_output_ena_l <= 1'b0;
                            idx_q           <= index_h;
                        end
                    end
                end
                LOOKUP: begin
                    tb_output_ena_l <= 1'b1;
                    tb_hit_h        <= tb_hit_out_h;
                    if (fault) begin
                        if (!(&perr_cnt_h))
                            perr_cnt_h <= perr_cnt_h + 1'b1;
`ifdef TLB_PERR_RETRY_EN
                        state         <= INV_ONE;
                        clear_valid_h <= 1'b1;
                        tb_grp_wr_h   <= 2'b11;
                        lru[idx_q]    <= 1'b0;
                        retry_q       <= 1'b1;
`else
                        state  <= IDLE;
                        busy_h <= 1'b0;
                        done_h <= 1'b1;
                        mchk_h <= 1'b1;
                        miss_h <= 1'b0;
`endif
                    end else begin
                        state  <= IDLE;
                        busy_h <= 1'b0;
                        done_h <= 1'b1;
                        miss_h <= ~hit_one;
                        if (hit_one)
                            lru[idx_q] <= hit_grp;
                    end
                end
                FILL: begin
                    state       <= IDLE;
                    busy_h      <= 1'b0;
                    done_h      <= 1'b1;
                    miss_h      <= 1'b0;
                    tb_grp_wr_h <= 2'b00;
                    pte_check_l <= 1'b1;
                end
                INV_ONE: begin
                    state         <= IDLE;
                    busy_h        <= 1'b0;
                    done_h        <= 1'b1;
                    tb_grp_wr_h   <= 2'b00;
                    clear_valid_h <= 1'b0;
`ifdef TLB_PERR_RETRY_EN
                    miss_h        <= retry_q;
                    retry_q       <= 1'b0;
`else
                    miss_h        <= 1'b0;
`endif
                end
                INV_ALL: begin
                    lru[inv_index_h] <= 1'b0;
                    if (&inv_index_h) begin
                        state         <= IDLE;
                        busy_h        <= 1'b0;
                        done_h        <= 1'b1;
                        miss_h        <= 1'b0;
                        inv_active_h  <= 1'b0;
                        clear_valid_h <= 1'b0;
                        tb_grp_wr_h   <= 2'b00;
                        inv_index_h   <= '0;
                    end else begin
                        inv_index_h <= inv_index_h + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_ctl.sv
// Directed bench for tlb_ctl: reset, lookup/fill/LRU, parity faults, sweep, reset mid-sweep, priority.
module tb_tlb_ctl;
    logic       b_clk_l = 1'b0;
    logic       init_l;
    logic       lookup_req_h, fill_req_h, inv_one_req_h, inv_all_req_h;
    logic [7:0] index_h;
    logic       diag_force_pe_h;
    logic [1:0] tb_hit_out_h, tb_tag_perr_h;
    logic       tb_data_perr_h;
    logic [1:0] tb_grp_wr_h, tb_hit_h;
    logic       tb_output_ena_l, pte_check_l, force_tb_pe_l, inv_active_h;
    logic [7:0] inv_index_h;
    logic       clear_valid_h, busy_h, done_h, miss_h, mchk_h;
    logic [3:0] perr_cnt_h;

    always #5 b_clk_l = ~b_clk_l;

    tlb_ctl #(.IDX_W(8), .PERR_CNT_W(4)) dut (
        .b_clk_l(b_clk_l), .init_l(init_l),
        .lookup_req_h(lookup_req_h), .fill_req_h(fill_req_h),
        .inv_one_req_h(inv_one_req_h), .inv_all_req_h(inv_all_req_h),
        .index_h(index_h), .diag_force_pe_h(diag_force_pe_h),
        .tb_hit_out_h(tb_hit_out_h), .tb_tag_perr_h(tb_tag_perr_h),
        .tb_data_perr_h(tb_data_perr_h),
        .tb_grp_wr_h(tb_grp_wr_h), .tb_hit_h(tb_hit_h),
        .tb_output_ena_l(tb_output_ena_l), .pte_check_l(pte_check_l),
        .force_tb_pe_l(force_tb_pe_l), .inv_active_h(inv_active_h),
        .inv_index_h(inv_index_h), .clear_valid_h(clear_valid_h),
        .busy_h(busy_h), .done_h(done_h), .miss_h(miss_h), .mchk_h(mchk_h),
        .perr_cnt_h(perr_cnt_h)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Results captured over one request, sampled on falling edges.
    int         r_cyc, r_mchk_n;
    logic [1:0] r_wr_or, r_hit;
    logic       r_pte_lo, r_oe_lo, r_clr, r_miss, r_busy;
    logic [3:0] r_perr;

    // req = {inv_all, inv_one, fill, lookup}
    task automatic do_req(input logic [3:0] req, input logic [7:0] idx,
                          input logic [1:0] hit, input logic [1:0] tagp, input logic datap);
        logic seen;
        @(negedge b_clk_l);
        {inv_all_req_h, inv_one_req_h, fill_req_h, lookup_req_h} = req;
        index_h = idx; tb_hit_out_h = hit; tb_tag_perr_h = tagp; tb_data_perr_h = datap;
        r_cyc = 0; r_mchk_n = 0; r_wr_or = 2'b00; r_hit = 2'b00;
        r_pte_lo = 0; r_oe_lo = 0; r_clr = 0; r_miss = 0; r_busy = 0; r_perr = 0;
        seen = 0;
        while (!seen && r_cyc < 400) begin
            @(negedge b_clk_l);
            r_cyc++;
            r_wr_or |= tb_grp_wr_h;
            if (!pte_check_l) r_pte_lo = 1;
            if (!tb_output_ena_l) r_oe_lo = 1;
            if (clear_valid_h) r_clr = 1;
            if (mchk_h) r_mchk_n++;
            if (done_h) begin
                seen = 1; r_miss = miss_h; r_hit = tb_hit_h; r_perr = perr_cnt_h; r_busy = busy_h;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        {inv_all_req_h, inv_one_req_h, fill_req_h, lookup_req_h} = 4'b0000;
        tb_hit_out_h = 2'b00; tb_tag_perr_h = 2'b00; tb_data_perr_h = 1'b0;
    endtask

    initial begin
        int errs, cyc, expi;
        init_l = 0; lookup_req_h = 0; fill_req_h = 0; inv_one_req_h = 0; inv_all_req_h = 0;
        index_h = 0; diag_force_pe_h = 0; tb_hit_out_h = 0; tb_tag_perr_h = 0; tb_data_perr_h = 0;
        repeat (3) @(posedge b_clk_l);
        @(negedge b_clk_l) init_l = 1;
        repeat (3) @(negedge b_clk_l);
        chk("rst_wr", tb_grp_wr_h, 0);
        chk("rst_hit", tb_hit_h, 0);
        chk("rst_oe", tb_output_ena_l, 1);
        chk("rst_pte", pte_check_l, 1);
        chk("rst_fpe", force_tb_pe_l, 1);
        chk("rst_inv", {inv_active_h, inv_index_h, clear_valid_h}, 0);
        chk("rst_stat", {busy_h, done_h, miss_h, mchk_h}, 0);
        chk("rst_perr", perr_cnt_h, 0);

        diag_force_pe_h = 1;
        @(negedge b_clk_l);
        chk("force_pe", force_tb_pe_l, 0);
        diag_force_pe_h = 0;

        // Cold lookup misses in two cycles without writing.
        do_req(4'b0001, 8'h12, 2'b00, 2'b00, 0);
        chk("lk_lat", r_cyc, 2);
        chk("lk_miss", r_miss, 1);
        chk("lk_wr", r_wr_or, 0);
        chk("lk_oe", r_oe_lo, 1);
        chk("lk_busy", r_busy, 0);

        do_req(4'b0010, 8'h12, 2'b00, 2'b00, 0);
        chk("fill1_wr", r_wr_or, 2'b10);
        chk("fill1_pte", r_pte_lo, 1);
        chk("fill1_lat", r_cyc, 2);
        do_req(4'b0010, 8'h12, 2'b00, 2'b00, 0);
        chk("fill2_wr", r_wr_or, 2'b01);

        do_req(4'b0001, 8'h12, 2'b10, 2'b00, 0);
        chk("hit_grp", r_hit, 2'b10);
        chk("hit_miss", r_miss, 0);
        chk("hit_mchk", r_mchk_n, 0);
        // Group 1 now most recent, so the victim is group 0.
        do_req(4'b0010, 8'h12, 2'b00, 2'b00, 0);
        chk("fill3_wr", r_wr_or, 2'b01);
        do_req(4'b0001, 8'h12, 2'b10, 2'b00, 0);
        do_req(4'b0010, 8'h55, 2'b00, 2'b00, 0);
        chk("fill55_wr", r_wr_or, 2'b10);

        // Double hit is a parity fault.
        do_req(4'b0001, 8'h20, 2'b11, 2'b00, 0);
        chk("dh_perr", r_perr, 1);
`ifdef TLB_PERR_RETRY_EN
        chk("dh_mchk", r_mchk_n, 0);
        chk("dh_miss", r_miss, 1);
        chk("dh_wr", r_wr_or, 2'b11);
        chk("dh_lat", r_cyc, 3);
`else
        chk("dh_mchk", r_mchk_n, 1);
        chk("dh_miss", r_miss, 0);
        chk("dh_wr", r_wr_or, 0);
        chk("dh_lat", r_cyc, 2);
`endif
        @(negedge b_clk_l);
        chk("mchk_pulse", mchk_h, 0);

        // Tag parity on the hitting group, then data parity.
        do_req(4'b0001, 8'h21, 2'b01, 2'b01, 0);
        chk("tag_perr", r_perr, 2);
`ifdef TLB_PERR_RETRY_EN
        chk("tag_wr", r_wr_or, 2'b11);
        chk("tag_res", {r_mchk_n[0], r_miss}, 2'b01);
`else
        chk("tag_res", {r_mchk_n[0], r_miss}, 2'b10);
`endif
        do_req(4'b0001, 8'h22, 2'b10, 2'b00, 1);
        chk("data_perr", r_perr, 3);
        repeat (20) do_req(4'b0001, 8'h23, 2'b11, 2'b00, 0);
        chk("perr_sat", r_perr, 15);

        do_req(4'b0100, 8'h12, 2'b00, 2'b00, 0);
        chk("inv1_wr", r_wr_or, 2'b11);
        chk("inv1_clr", r_clr, 1);
        chk("inv1_lat", r_cyc, 2);

        // Full sweep.
        @(negedge b_clk_l);
        inv_all_req_h = 1;
        errs = 0; cyc = 0; expi = 0;
        while (!done_h && cyc < 600) begin
            @(negedge b_clk_l);
            cyc++;
            if (inv_active_h) begin
                if (inv_index_h !== expi[7:0] || tb_grp_wr_h !== 2'b11 || clear_valid_h !== 1'b1) errs++;
                expi++;
            end
        end
        inv_all_req_h = 0;
        chk("sweep_seq", errs, 0);
        chk("sweep_cnt", expi, 256);
        chk("sweep_lat", cyc, 257);
        chk("sweep_end", {inv_active_h, inv_index_h, busy_h}, 0);
        do_req(4'b0010, 8'h55, 2'b00, 2'b00, 0);
        chk("post_sweep_wr", r_wr_or, 2'b10);

        // Reset in the middle of a sweep.
        do_req(4'b0010, 8'h33, 2'b00, 2'b00, 0);
        @(negedge b_clk_l);
        inv_all_req_h = 1;
        cyc = 0;
        while (inv_index_h !== 8'h40 && cyc < 200) begin
            @(negedge b_clk_l);
            cyc++;
        end
        chk("sweep_reach40", inv_index_h, 8'h40);
        init_l = 0; inv_all_req_h = 0;
        @(negedge b_clk_l);
        chk("abort_inv", {inv_active_h, inv_index_h}, 0);
        chk("abort_stat", {busy_h, clear_valid_h, tb_grp_wr_h}, 0);
        init_l = 1;

        // Fill outranks lookup; LRU at 0x33 was cleared by the reset.
        do_req(4'b0011, 8'h33, 2'b01, 2'b00, 0);
        chk("prio_wr", r_wr_or, 2'b10);
        chk("prio_oe", r_oe_lo, 0);
        chk("prio_lat", r_cyc, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tlb_ctl.md
Name: tlb_ctl

Overview:
Sequencer for the two-group translation buffer in the MIC.
- Accepts lookup, fill, invalidate-single and invalidate-all requests from the microsequencer.
- Drives the TB write strobes, hit-group select, output enable and PTE-check controls.
- Keeps a per-index LRU bit that chooses the fill victim group.
- Detects tag, data and multi-hit parity faults and reports them as a machine check.

Parameters:
IDX_W, 8, TB index width; sweep length is 2**IDX_W entries.
PERR_CNT_W, 4, width of the saturating parity-error counter.

Ports:
b_clk_l  in  1  clock; all state advances on the rising edge.
init_l  in  1  reset, synchronous, active-low.
lookup_req_h  in  1  request a lookup at index_h.
fill_req_h  in  1  request a write of the PTE on pad into the victim group.
inv_one_req_h  in  1  request invalidation of both groups at index_h.
inv_all_req_h  in  1  request invalidation of the whole TB.
index_h  in  IDX_W  current TB index, taken from the address bus.
diag_force_pe_h  in  1  diagnostic: force bad parity.
tb_hit_out_h  in  2  raw per-group hit from the TB.
tb_tag_perr_h  in  2  per-group tag parity error.
tb_data_perr_h  in  1  data parity error.
tb_grp_wr_h  out  2  per-group write strobe.
tb_hit_h  out  2  registered hit-group select.
tb_output_ena_l  out  1  TB output enable, active low.
pte_check_l  out  1  low selects pad-sourced AC/M bits (fill).
force_tb_pe_l  out  1  equals ~diag_force_pe_h, registered.
inv_active_h  out  1  high: index and valid are overridden by this block.
inv_index_h  out  IDX_W  override index during invalidation.
clear_valid_h  out  1  forces the written valid bit to 0.
busy_h  out  1  high when not in IDLE.
done_h  out  1  one-cycle completion pulse.
miss_h  out  1  lookup result is a miss; valid with done_h.
mchk_h  out  1  one-cycle parity machine-check pulse.
perr_cnt_h  out  PERR_CNT_W  saturating parity-fault count.

Behaviour:
Reset (init_l=0 at a clock edge), any state:
- State goes to IDLE; an in-progress sweep is aborted.
- tb_grp_wr_h=0, tb_hit_h=0, tb_output_ena_l=1, pte_check_l=1, force_tb_pe_l=1.
- inv_active_h=0, inv_index_h=0, clear_valid_h=0, busy_h=0, done_h=0, miss_h=0, mchk_h=0, perr_cnt_h=0.
- All LRU bits are cleared to 0.

Request handling:
- Requests are levels, sampled only in IDLE; the requester holds its request until done_h.
- Priority when several are high: inv_all > inv_one > fill > lookup.

States:
- IDLE:
  - All strobes are inactive.
  - Selects the next state by request priority.
- LOOKUP (1 cycle):
  - tb_output_ena_l=0; tb_hit_h is loaded with tb_hit_out_h.
  - Next cycle: done_h=1 and the result is evaluated:
    - Exactly one hit, no tag parity error on that group, no data parity error: miss_h=0 and lru[index]=hit group.
    - No hit and no parity error: miss_h=1; LRU unchanged.
    - Both groups hit, or a parity error on a hit group, or a data parity error: parity fault.
  - Total latency is 2 cycles, request to done_h.
- FILL (1 cycle):
  - Victim = ~lru[index_h].
  - pte_check_l=0 and tb_grp_wr_h[victim]=1.
  - lru[index_h]=victim.
  - done_h is asserted on the next cycle.
- INV_ONE (1 cycle):
  - tb_grp_wr_h=2'b11 and clear_valid_h=1.
  - lru[index_h] is cleared.
  - done_h is asserted on the next cycle.
- INV_ALL:
  - inv_active_h=1, clear_valid_h=1, tb_grp_wr_h=2'b11.
  - inv_index_h counts 0 to 2**IDX_W-1, one index per cycle, and clears the LRU bit of each index.
  - After the last index the counter wraps to 0 and done_h is asserted.
  - Total: 2**IDX_W write cycles, then done_h.
- PERR (fault path, without the optional feature):
  - mchk_h and done_h pulse for 1 cycle, with miss_h=0.
  - perr_cnt_h increments and saturates at all-ones.

Other rules:
- tb_grp_wr_h is never nonzero in IDLE or LOOKUP.
- inv_active_h is high only in INV_ALL.
- busy_h deasserts in the cycle done_h is high.

Optional Feature:
TLB_PERR_RETRY_EN.
- Defined: a parity fault does not raise mchk_h. perr_cnt_h still increments. The block enters INV_ONE at the faulting index, then pulses done_h with miss_h=1, so microcode refills the entry.
- Undefined: a parity fault pulses mchk_h with done_h and miss_h=0, as described under PERR.

Test Plan:
- Reset, then idle 3 cycles -> every output at its reset value; lookup at index 0x12 -> miss_h=1 with done_h on cycle 2; tb_grp_wr_h stays 0.
- Fill at 0x12 twice -> first fill writes group 1 (tb_grp_wr_h=2'b10), second writes group 0 (2'b01); lookup with tb_hit_out_h=2'b10 -> tb_hit_h=2'b10, miss_h=0.
- Lookup with tb_hit_out_h=2'b11 -> mchk_h pulses once, perr_cnt_h=1; repeat 20 times -> perr_cnt_h saturates at 15.
- inv_all_req_h -> inv_index_h steps 0x00..0xFF over 256 cycles with tb_grp_wr_h=2'b11 and clear_valid_h=1; done_h follows; a subsequent fill at any index writes group 1.
- init_l low at sweep index 0x40 -> next cycle IDLE, inv_active_h=0, inv_index_h=0; fill and lookup requests raised together -> fill is serviced first.
- With TLB_PERR_RETRY_EN: tb_tag_perr_h=2'b01 on a group-0 hit -> INV_ONE write (2'b11), then done_h with miss_h=1 and mchk_h=0.
